inst_encoder: RTL and testbench

Instruction encoder and program-stream packer: the inverse of the immediate generator. Accepts decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake. Emits the packed 32-bit RV32I word plus an auto-incrementing word address for writing instruction memory from the bench or loader side. For every legal input, passing `out_inst` back through the immediate generator reproduces `imm` exactly. Unrepresentable immediates are flagged.

---
 rtl/inst_encoder.sv | 146 ++++++++++++++
 tb/tb_inst_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, tags it with an
// auto-incrementing word address and flags immediates the chosen format cannot represent.
module inst_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [31:0] enc_word;
  logic        enc_bad;
  logic        accept;

  // Upper immediate bits must all be copies of the sign bit to survive truncation.
  logic sext12_ok, sext13_ok, sext21_ok;
  assign sext12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext13_ok = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext21_ok = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = Nop;
    enc_bad  = 1'b1;
    case (fmt)
      FmtR: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_bad  = 1'b0;
      end
      FmtI: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_bad  = ~sext12_ok;
      end
      FmtS: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_bad  = ~sext12_ok;
      end
      FmtB: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_bad  = ~sext13_ok | imm[0];
      end
      FmtU: begin
        enc_word = {imm[31:12], rd, opcode};
        enc_bad  = |imm[11:0];
      end
      FmtJ: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_bad  = ~sext21_ok | imm[0];
      end
      default: begin
        enc_word = Nop;
        enc_bad  = 1'b1;
      end
    endcase
  end

  assign in_ready = ~rst & ~clr & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    addr_cnt_d  = addr_cnt_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    if (clr) begin
      out_valid_d = 1'b0;
      out_inst_d  = '0;
      out_addr_d  = '0;
      addr_cnt_d  = '0;
      err_d       = 1'b0;
      err_addr_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_word;
      out_addr_d  = addr_cnt_q;
      addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
      if (enc_bad) begin
        err_d = 1'b1;
        // Only the first offending word since reset/clr is remembered.
        if (!err_q) begin
          err_addr_d = addr_cnt_q;
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      addr_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      addr_cnt_q  <= addr_cnt_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed plan vectors plus a randomized stream, compared every cycle
// against a field-level reference model and an immediate-generator round trip.
module tb_inst_encoder;

  localparam int AW = 4;

  logic          clk;
  logic          rst, clr, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]    fmt, funct3;
  logic [6:0]    opcode, funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm, out_inst;
  logic [AW-1:0] out_addr, err_addr;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fmt      (fmt),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_addr (out_addr),
    .err      (err),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic          m_v = 1'b0;
  logic [31:0]   m_inst = '0;
  logic [AW-1:0] m_addr = '0, m_cnt = '0, m_erra = '0;
  logic          m_err = 1'b0, m_legal = 1'b0;
  logic [2:0]    m_fmt = '0;
  logic [31:0]   m_imm = '0;
  logic          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected word built from the field layout with shifts and masks; range from signed bounds.
  function automatic void ref_enc(input logic [2:0] f, input logic [31:0] i,
                                  output logic [31:0] w, output logic bad);
    int s;
    logic [31:0] base;
    s = $signed(i);
    base = (32'(funct3) << 12) | 32'(opcode);
    bad = 1'b0;
    case (f)
      3'd0: w = (32'(funct7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | base;
      3'd1: begin
        w = ((i & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | base;
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((i >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
            | ((i & 32'h1f) << 7) | base;
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3f) << 25) | (32'(rs2) << 20)
            | (32'(rs1) << 15) | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 1) << 7) | base;
        bad = (s < -4096) || (s > 4095) || (i[0] == 1'b1);
      end
      3'd4: begin
        w = (i & 32'hffff_f000) | (32'(rd) << 7) | 32'(opcode);
        bad = (i % 4096) != 0;
      end
      3'd5: begin
        w = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3ff) << 21) | (((i >> 11) & 1) << 20)
            | (((i >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'(opcode);
        bad = (s < -(1 << 20)) || (s > (1 << 20) - 1) || (i[0] == 1'b1);
      end
      default: begin
        w = 32'h13;
        bad = 1'b1;
      end
    endcase
  endfunction

  // Immediate generator: recovers the sign-extended immediate from an encoded word.
  function automatic logic [31:0] immgen(input logic [31:0] word, input logic [2:0] f);
    int w;
    w = $signed(word);
    case (f)
      3'd1: return 32'(w >>> 20);
      3'd2: return 32'(((w >>> 25) << 5) | ((w >> 7) & 31));
      3'd3: return 32'(((w >>> 31) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5)
                       | (((w >> 8) & 15) << 1));
      3'd4: return word & 32'hffff_f000;
      3'd5: return 32'(((w >>> 31) << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11)
                       | (((w >> 21) & 1023) << 1));
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    logic exp_rdy;
    logic [31:0] w;
    logic bad;
    @(negedge clk);
    exp_rdy = !rst && !clr && (!m_v || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    last_acc = in_valid && exp_rdy;
    ref_enc(fmt, imm, w, bad);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_inst = 0; m_addr = 0; m_cnt = 0; m_err = 0; m_erra = 0;
    end else if (clr) begin
      m_v = 0; m_cnt = 0; m_err = 0; m_erra = 0;
    end else if (last_acc) begin
      m_v = 1; m_inst = w; m_addr = m_cnt; m_cnt = m_cnt + 1'b1;
      m_fmt = fmt; m_imm = imm; m_legal = !bad;
      if (bad && !m_err) m_erra = m_addr;
      if (bad) m_err = 1;
    end else if (m_v && out_ready) begin
      m_v = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("err", 32'(err), 32'(m_err));
    chk("err_addr", 32'(err_addr), 32'(m_erra));
    if (m_v || rst) begin
      chk("out_inst", out_inst, m_inst);
      chk("out_addr", 32'(out_addr), 32'(m_addr));
    end
    if (m_v && m_legal && m_fmt >= 3'd1 && m_fmt <= 3'd5)
      chk("roundtrip", immgen(out_inst, m_fmt), m_imm);
  endtask

  task automatic put(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] i);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = i;
    in_valid = 1'b1;
  endtask

  task automatic put_rand();
    logic [31:0] i;
    case ($urandom_range(0, 3))
      0: i = 32'($signed($urandom_range(0, 8191)) - 4096);
      1: i = $urandom;
      2: i = $urandom & 32'hffff_f000;
      default: i = 32'($signed($urandom_range(0, 32'h3f_ffff)) - 32'h20_0000);
    endcase
    put(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        3'($urandom), 7'($urandom), i);
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0; out_ready = 1;
    put(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    tick(); tick();
    chk("rst_inst", out_inst, 32'h0);
    rst = 0;

    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    chk("I_word", out_inst, 32'h0050_0093);
    chk("I_addr", 32'(out_addr), 32'd0);
    put(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    chk("S_word", out_inst, 32'h0020_A423);
    chk("S_addr", 32'(out_addr), 32'd1);
    put(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
    tick();
    chk("Ierr_word", out_inst, 32'h0000_0093);
    chk("Ierr_flag", 32'(err), 32'd1);
    chk("Ierr_addr", 32'(err_addr), 32'd2);
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    chk("Berr_keep", 32'(err_addr), 32'd2);
    put(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'd1, 32'd0);
    tick();
    chk("illegal_nop", out_inst, 32'h0000_0013);

    in_valid = 0; out_ready = 0; clr = 1;
    tick();
    clr = 0; out_ready = 1;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    put(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
    tick();
    chk("B_word", out_inst, 32'hFE00_0EE3);
    chk("B_addr", 32'(out_addr), 32'd0);
    put(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    tick();
    chk("J_word", out_inst, 32'h0010_00EF);
    chk("J_addr", 32'(out_addr), 32'd1);
    in_valid = 0;
    tick();

    // Backpressure: hold the consumer off for two stalled cycles, then release.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      int stalls = 0;
      put(3'd1, 7'h13, 5'(k + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(k * 7));
      tick();
      while (!last_acc && stalls < 8) begin
        stalls++;
        if (stalls >= 2) out_ready = 1;
        tick();
      end
      if (!last_acc) chk("bp_timeout", 32'd0, 32'd1);
    end
    in_valid = 0; out_ready = 1;
    tick();

    for (int n = 0; n < 600; n++) begin
      put_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 49) == 0);
      tick();
    end
    clr = 0;

    // Reset while holding a word: it must be dropped.
    out_ready = 1;
    put(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    out_ready = 0; in_valid = 1; rst = 1;
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    rst = 0; in_valid = 0; out_ready = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
